// File: rtl/snake_pkg.sv
// Shared encodings for the snake body engine: FSM states, move directions
// and the reverse-direction helper used by the direction latch.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_GG    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_L = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  // R<->L and U<->D differ only in bit 0
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-rate divider: counts enabled cycles 0..TICK_DIV-1 and flags the wrap
// cycle. The count freezes while disabled so a pause resumes mid-interval.
module snake_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic step
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == TW'(TICK_DIV - 1));
  assign step = en && wrap;

  // divider counter, advances only when enabled
  always_ff @(posedge CLK) begin
    if (RESET)   cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + TW'(1);
  end

endmodule

// File: rtl/snake_body_engine.sv
// Grid snake core: segment shift register, direction latch, growth,
// wall/self collision, game FSM and a registered per-cell query port.
// Build option: define WRAP_WALLS_EN to make the head wrap around the grid
// edges instead of ending the game on a wall.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 20,
  parameter int GRID_H   = 15,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 25000000,
  localparam int CW = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          btn_l,
  input  logic          btn_r,
  input  logic          btn_u,
  input  logic          btn_d,
  input  logic          start,
  input  logic          pause,
  input  logic [CW-1:0] food_x,
  input  logic [CW-1:0] food_y,
  input  logic [CW-1:0] qry_x,
  input  logic [CW-1:0] qry_y,
  output logic          qry_hit,
  output logic          qry_head,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic [1:0]    state,
  output logic          step,
  output logic          food_eaten
);

  typedef logic [MAX_LEN-1:0][CW-1:0] seg_arr_t;

  function automatic seg_arr_t init_x();
    seg_arr_t r;
    for (int i = 0; i < MAX_LEN; i++)
      r[i] = (i < INIT_LEN) ? CW'(GRID_W / 2 - i) : '0;
    return r;
  endfunction

  function automatic seg_arr_t init_y();
    seg_arr_t r;
    for (int i = 0; i < MAX_LEN; i++)
      r[i] = CW'(GRID_H / 2);
    return r;
  endfunction

  localparam seg_arr_t INIT_X = init_x();
  localparam seg_arr_t INIT_Y = init_y();

  state_t          st;
  dir_t            dir, last_dir, req, dir_nx;
  logic            req_vld;
  seg_arr_t        seg_x, seg_y;
  logic [LW-1:0]   len, len_lim;
  logic [CW-1:0]   nx, ny;
  logic            wall, blocked, eat, grow, collide, tick;
  logic [MAX_LEN-1:0] hit_self, q_m;

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = len;
  assign state  = st;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RESET(RESET),
    .en   (st == ST_PLAY),
    .step (tick)
  );

  // direction request: reversals of the last executed move are masked first, then L>R>U>D
  always_comb begin
    req_vld = 1'b1;
    req     = dir;
    if      (btn_l && opposite(DIR_L) != last_dir) req = DIR_L;
    else if (btn_r && opposite(DIR_R) != last_dir) req = DIR_R;
    else if (btn_u && opposite(DIR_U) != last_dir) req = DIR_U;
    else if (btn_d && opposite(DIR_D) != last_dir) req = DIR_D;
    else                                           req_vld = 1'b0;
    dir_nx = (st == ST_PLAY && req_vld) ? req : dir;
  end

  // candidate head cell; on an edge the wrapped cell is prepared and wall flags it
  always_comb begin
    nx   = seg_x[0];
    ny   = seg_y[0];
    wall = 1'b0;
    case (dir_nx)
      DIR_R: if (seg_x[0] == CW'(GRID_W - 1)) begin wall = 1'b1; nx = '0; end
             else nx = seg_x[0] + CW'(1);
      DIR_L: if (seg_x[0] == '0) begin wall = 1'b1; nx = CW'(GRID_W - 1); end
             else nx = seg_x[0] - CW'(1);
      DIR_U: if (seg_y[0] == '0) begin wall = 1'b1; ny = CW'(GRID_H - 1); end
             else ny = seg_y[0] - CW'(1);
      default: if (seg_y[0] == CW'(GRID_H - 1)) begin wall = 1'b1; ny = '0; end
               else ny = seg_y[0] + CW'(1);
    endcase
  end

`ifdef WRAP_WALLS_EN
  assign blocked = 1'b0;
`else
  assign blocked = wall;
`endif

  assign eat  = (nx == food_x) && (ny == food_y);
  assign grow = eat && (len < LW'(MAX_LEN));
  // the tail vacates its cell on a plain move, so it only blocks when growing
  assign len_lim = grow ? len : len - LW'(1);

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign hit_self[i] = (seg_x[i] == nx) && (seg_y[i] == ny) && (LW'(i) < len_lim);
    assign q_m[i]      = (seg_x[i] == qry_x) && (seg_y[i] == qry_y) && (LW'(i) < len);
  end

  assign collide = blocked || (|hit_self);

  // game FSM, body shift register and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st         <= ST_IDLE;
      dir        <= DIR_R;
      last_dir   <= DIR_R;
      len        <= LW'(INIT_LEN);
      seg_x      <= INIT_X;
      seg_y      <= INIT_Y;
      step       <= 1'b0;
      food_eaten <= 1'b0;
      qry_hit    <= 1'b0;
      qry_head   <= 1'b0;
    end else begin
      step       <= 1'b0;
      food_eaten <= 1'b0;
      qry_hit    <= |q_m;
      qry_head   <= (seg_x[0] == qry_x) && (seg_y[0] == qry_y);
      case (st)
        ST_IDLE: if (start || btn_l || btn_r || btn_u || btn_d) st <= ST_PLAY;
        ST_PLAY: begin
          dir <= dir_nx;
          if (tick && collide) st <= ST_GG;
          else begin
            if (tick) begin
              seg_x      <= {seg_x[MAX_LEN-2:0], nx};
              seg_y      <= {seg_y[MAX_LEN-2:0], ny};
              len        <= len + LW'(grow);
              last_dir   <= dir_nx;
              step       <= 1'b1;
              food_eaten <= eat;
            end
            if (pause) st <= ST_PAUSE;
          end
        end
        ST_PAUSE: if (pause) st <= ST_PLAY;
        default: if (start) begin
          st       <= ST_IDLE;
          dir      <= DIR_R;
          last_dir <= DIR_R;
          len      <= LW'(INIT_LEN);
          seg_x    <= INIT_X;
          seg_y    <= INIT_Y;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine with TICK_DIV=4 on the default grid.
module tb_snake_body_engine;

  logic       CLK = 1'b0;
  logic       RESET, btn_l, btn_r, btn_u, btn_d, start, pause;
  logic [4:0] food_x, food_y, qry_x, qry_y, head_x, head_y, length;
  logic       qry_hit, qry_head, step, food_eaten;
  logic [1:0] state;

  int n_chk = 0;
  int n_fail = 0;

  snake_body_engine #(.TICK_DIV(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .start(start), .pause(pause),
    .food_x(food_x), .food_y(food_y), .qry_x(qry_x), .qry_y(qry_y),
    .qry_hit(qry_hit), .qry_head(qry_head),
    .head_x(head_x), .head_y(head_y), .length(length), .state(state),
    .step(step), .food_eaten(food_eaten)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] qx, qy;
    logic       hit, head;
  } qv_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; start = 1'b0; pause = 1'b0;
    btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
    cyc();
    RESET = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; cyc(); pause = 1'b0;
  endtask

  // waits for the next step pulse; a missing step is a failed comparison
  task automatic wait_step(input string nm, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n++;
      if (step) begin got = 1'b1; break; end
    end
    chk(nm, {31'd0, got}, 32'd1);
  endtask

  task automatic head_is(input string nm, input int x, input int y);
    chk(nm, {22'd0, head_x, head_y}, (x << 5) | y);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    qv_t qv[7];
    int  n;
    qv[0] = '{5'd9,  5'd7, 1'b1, 1'b0};
    qv[1] = '{5'd10, 5'd7, 1'b1, 1'b1};
    qv[2] = '{5'd5,  5'd7, 1'b0, 1'b0};
    qv[3] = '{5'd7,  5'd7, 1'b1, 1'b0};
    qv[4] = '{5'd6,  5'd7, 1'b0, 1'b0};
    qv[5] = '{5'd10, 5'd6, 1'b0, 1'b0};
    qv[6] = '{5'd0,  5'd0, 1'b0, 1'b0};

    food_x = 5'd0; food_y = 5'd0; qry_x = 5'd0; qry_y = 5'd0;
    do_reset();

    // reset state
    chk("rst_state", {30'd0, state}, 32'd0);
    head_is("rst_head", 10, 7);
    chk("rst_len", {27'd0, length}, 32'd4);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_food_eaten", {31'd0, food_eaten}, 32'd0);
    chk("rst_qry_hit", {31'd0, qry_hit}, 32'd0);
    chk("rst_qry_head", {31'd0, qry_head}, 32'd0);

    // query table on the reset layout
    foreach (qv[i]) begin
      qry_x = qv[i].qx; qry_y = qv[i].qy;
      cyc();
      chk($sformatf("qry_hit[%0d]", i),  {31'd0, qry_hit},  {31'd0, qv[i].hit});
      chk($sformatf("qry_head[%0d]", i), {31'd0, qry_head}, {31'd0, qv[i].head});
    end

    // run right into the wall
    pulse_start();
    chk("t1_play", {30'd0, state}, 32'd1);
    for (int s = 0; s < 9; s++) begin
      wait_step($sformatf("t1_step%0d", s), n);
      if (s < 2) chk($sformatf("t1_period%0d", s), n, 4);
    end
    head_is("t1_head9", 19, 7);
    repeat (4) cyc();
`ifdef WRAP_WALLS_EN
    chk("t1_wrap_state", {30'd0, state}, 32'd1);
    head_is("t1_wrap_head", 0, 7);
`else
    chk("t1_gg_state", {30'd0, state}, 32'd3);
    head_is("t1_gg_head", 19, 7);
    pulse_start();
    chk("t1_gg_idle", {30'd0, state}, 32'd0);
    head_is("t1_idle_head", 10, 7);
`endif

    // growth on the second step
    do_reset();
    food_x = 5'd12; food_y = 5'd7;
    pulse_start();
    wait_step("t2_step1", n);
    chk("t2_no_eat", {31'd0, food_eaten}, 32'd0);
    wait_step("t2_step2", n);
    chk("t2_eat", {31'd0, food_eaten}, 32'd1);
    chk("t2_len", {27'd0, length}, 32'd5);
    head_is("t2_head", 12, 7);
    qry_x = 5'd8; qry_y = 5'd7;
    cyc();
    chk("t2_eat_pulse", {31'd0, food_eaten}, 32'd0);
    chk("t2_tail_hit", {31'd0, qry_hit}, 32'd1);

    // reversal rejection and priority masking
    do_reset();
    food_x = 5'd0; food_y = 5'd0;
    pulse_start();
    wait_step("t3_step1", n);
    btn_l = 1'b1;
    wait_step("t3_step2", n);
    head_is("t3_l_ignored", 12, 7);
    btn_u = 1'b1;
    wait_step("t3_step3", n);
    head_is("t3_lu_up", 12, 6);
    btn_l = 1'b0; btn_u = 1'b0;

    // head enters the vacated tail cell
    do_reset();
    pulse_start();
    btn_u = 1'b1; wait_step("t4_u", n); btn_u = 1'b0;
    btn_l = 1'b1; wait_step("t4_l", n); btn_l = 1'b0;
    btn_d = 1'b1; wait_step("t4_d", n); btn_d = 1'b0;
    head_is("t4_head", 9, 7);
    chk("t4_state", {30'd0, state}, 32'd1);
    chk("t4_len", {27'd0, length}, 32'd4);

    // after growing the old tail cell is occupied -> self collision
    do_reset();
    food_x = 5'd11; food_y = 5'd7;
    pulse_start();
    wait_step("t5_eat_step", n);
    chk("t5_eat", {31'd0, food_eaten}, 32'd1);
    chk("t5_len", {27'd0, length}, 32'd5);
    food_x = 5'd0; food_y = 5'd0;
    btn_u = 1'b1; wait_step("t5_u", n); btn_u = 1'b0;
    btn_l = 1'b1; wait_step("t5_l", n); btn_l = 1'b0;
    btn_d = 1'b1;
    repeat (4) cyc();
    btn_d = 1'b0;
    chk("t5_gg", {30'd0, state}, 32'd3);
    head_is("t5_head", 10, 6);
    chk("t5_len_kept", {27'd0, length}, 32'd5);
    btn_r = 1'b1; cyc(); btn_r = 1'b0;
    chk("t5_gg_ignores_btn", {30'd0, state}, 32'd3);
    pulse_start();
    chk("t5_idle", {30'd0, state}, 32'd0);
    chk("t5_len_init", {27'd0, length}, 32'd4);
    qry_x = 5'd11; qry_y = 5'd7;
    cyc();
    chk("t5_old_body_gone", {31'd0, qry_hit}, 32'd0);
    btn_r = 1'b1; cyc(); btn_r = 1'b0;
    chk("t5_btn_starts", {30'd0, state}, 32'd1);

    // pause freezes stepping
    do_reset();
    pulse_start();
    wait_step("t6_step1", n);
    pulse_pause();
    chk("t6_paused", {30'd0, state}, 32'd2);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (step) n++;
    end
    chk("t6_no_steps", n, 0);
    head_is("t6_head_frozen", 11, 7);
    pulse_pause();
    chk("t6_resumed", {30'd0, state}, 32'd1);
    wait_step("t6_step2", n);
    head_is("t6_head_moves", 12, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
